// File: rtl/rpn_stack_ctrl.sv
// RPN stack sequencer: PUSH/CLEAR/errors and DROP of a depth-1 stack finish in 1 cycle, a DROP that refills top in 3, ALU ops in 4.
// cmd_ready is low while a multi-cycle command runs; cmd_valid seen while busy is dropped, not queued.
module rpn_stack_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  output logic [DW-1:0] top,
  output logic [AW:0]   depth,
  output logic          resp_valid,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WB,
    S_DRD,
    S_DCAP
  } state_t;

  localparam logic [2:0]  OP_PUSH   = 3'b000;
  localparam logic [2:0]  OP_ADD    = 3'b001;
  localparam logic [2:0]  OP_SUB    = 3'b010;
  localparam logic [2:0]  OP_MUL    = 3'b011;
  localparam logic [2:0]  OP_AND    = 3'b100;
  localparam logic [2:0]  OP_DROP   = 3'b101;
  localparam logic [2:0]  OP_CLEAR  = 3'b110;
  localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [AW:0] TWO       = (AW+1)'(2);

  state_t        state_q, state_d;
  logic [AW:0]   depth_q, depth_d;
  logic [DW-1:0] top_q, top_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_wren_q, mem_wren_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          resp_valid_q, resp_valid_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          err_op_q, err_op_d;

  logic          accept;
  logic [AW-1:0] addr_below;

  assign accept     = cmd_valid && (state_q == S_IDLE);
  // Second-from-top slot; modulo 2**AW so a completely full RAM still wraps correctly.
  assign addr_below = depth_q[AW-1:0] - AW'(2);

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    top_d        = top_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wren_d   = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_valid_d = 1'b0;
    err_ovf_d    = err_ovf_q;
    err_unf_d    = err_unf_q;
    err_op_d     = err_op_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
          err_op_d  = 1'b0;
          case (cmd_op)
            OP_PUSH: begin
              resp_valid_d = 1'b1;
              if (depth_q == DEPTH_MAX) begin
                err_ovf_d = 1'b1;
              end else begin
                mem_addr_d = depth_q[AW-1:0];
                mem_data_d = cmd_data;
                mem_wren_d = 1'b1;
                depth_d    = depth_q + ONE;
                top_d      = cmd_data;
              end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND: begin
              if (depth_q < TWO) begin
                err_unf_d    = 1'b1;
                resp_valid_d = 1'b1;
              end else begin
                mem_addr_d = addr_below;
                // 001..100 map onto ALU codes 00..11 by subtracting one in two bits
                alu_op_d   = cmd_op[1:0] - 2'd1;
                alu_b_d    = top_q;
                state_d    = S_RD;
              end
            end
            OP_DROP: begin
              if (depth_q == '0) begin
                err_unf_d    = 1'b1;
                resp_valid_d = 1'b1;
              end else if (depth_q == ONE) begin
                depth_d      = '0;
                top_d        = '0;
                resp_valid_d = 1'b1;
              end else begin
                depth_d    = depth_q - ONE;
                mem_addr_d = addr_below;
                state_d    = S_DRD;
              end
            end
            OP_CLEAR: begin
              depth_d      = '0;
              top_d        = '0;
              resp_valid_d = 1'b1;
            end
            default: begin
              err_op_d     = 1'b1;
              resp_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        alu_a_d = mem_q;
        state_d = S_WB;
      end
      S_WB: begin
        mem_addr_d   = addr_below;
        mem_data_d   = alu_out;
        mem_wren_d   = 1'b1;
        top_d        = alu_out;
        depth_d      = depth_q - ONE;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_DRD: state_d = S_DCAP;
      S_DCAP: begin
        top_d        = mem_q;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      depth_q      <= '0;
      top_q        <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wren_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_valid_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      err_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      top_q        <= top_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wren_q   <= mem_wren_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_valid_q <= resp_valid_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
      err_op_q     <= err_op_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign top        = top_q;
  assign depth      = depth_q;
  assign resp_valid = resp_valid_q;
  assign err_ovf    = err_ovf_q;
  assign err_unf    = err_unf_q;
  assign err_op     = err_op_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl with a 4-entry stack: directed vector table, reset-mid-operation case,
// then random commands checked against a queue-based stack model; RAM and ALU are modelled here.
module tb_rpn_stack_ctrl;
  localparam int DW = 8, AW = 2, DEPTH = 4;
  localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3, AND_ = 3'd4,
                         DROP = 3'd5, CLR = 3'd6, ILL = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_valid, cmd_ready, mem_wren, resp_valid, err_ovf, err_unf, err_op;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data, mem_data, mem_q, alu_a, alu_b, alu_out, top;
  logic [AW-1:0] mem_addr;
  logic [1:0]    alu_op;
  logic [AW:0]   depth;

  rpn_stack_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .top(top), .depth(depth), .resp_valid(resp_valid),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_op(err_op)
  );

  // Single-port synchronous RAM: read data appears the cycle after the address is sampled.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  always_comb begin
    case (alu_op)
      2'd0:    alu_out = alu_a + alu_b;
      2'd1:    alu_out = alu_a - alu_b;
      2'd2:    alu_out = alu_a * alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  int vectors = 0, errors = 0, wr_seen = 0, wr_exp = 0;
  always @(negedge clk) if (mem_wren === 1'b1) wr_seen++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stack as a queue, last element is the top.
  logic [DW-1:0] stk[$];
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdat, m_top;
  logic [2:0]    m_err;
  int            m_depth, m_lat;

  task automatic model_step(input logic [2:0] op, input logic [DW-1:0] data);
    int d;
    logic [DW-1:0] a, b, r;
    d = stk.size();
    m_err = 3'b000; m_wr = 1'b0; m_lat = 1; m_addr = '0; m_wdat = '0;
    case (op)
      PUSH: if (d == DEPTH) m_err = 3'b100;
            else begin m_wr = 1'b1; m_addr = AW'(d); m_wdat = data; stk.push_back(data); end
      ADD, SUB, MUL, AND_: begin
        if (d < 2) m_err = 3'b010;
        else begin
          a = stk[d-2]; b = stk[d-1];
          case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            MUL:     r = a * b;
            default: r = a & b;
          endcase
          void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(r);
          m_wr = 1'b1; m_addr = AW'(d - 2); m_wdat = r; m_lat = 4;
        end
      end
      DROP: if (d == 0) m_err = 3'b010;
            else begin void'(stk.pop_back()); if (d >= 2) m_lat = 3; end
      CLR:  stk.delete();
      default: m_err = 3'b001;
    endcase
    m_depth = stk.size();
    m_top   = (m_depth == 0) ? '0 : stk[m_depth-1];
  endtask

  // Issue one command and follow it to its response; junk is driven on cmd_* while busy.
  task automatic apply(input logic [2:0] op, input logic [DW-1:0] data, input logic [DW-1:0] e_top,
                       input int e_depth, input logic [2:0] e_err, input int e_lat);
    int n;
    bit seen;
    @(negedge clk);
    chk("ready_at_issue", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    n = 0; seen = 0;
    while (!seen && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (resp_valid) seen = 1;
      else begin
        chk("ready_low_busy", 32'(cmd_ready), 0);
        cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_data = DW'($urandom);
      end
    end
    cmd_valid = 1'b0;
    chk("resp_seen", 32'(seen), 1);
    chk("latency", 32'(n), 32'(e_lat));
    chk("top", 32'(top), 32'(e_top));
    chk("depth", 32'(depth), 32'(e_depth));
    chk("err_ovf_unf_op", 32'({err_ovf, err_unf, err_op}), 32'(e_err));
    chk("ready_at_resp", 32'(cmd_ready), 1);
    chk("mem_wren", 32'(mem_wren), 32'(m_wr));
    if (m_wr) begin
      wr_exp++;
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_data", 32'(mem_data), 32'(m_wdat));
    end
  endtask

  task automatic check_ram();
    @(posedge clk); #1;
    for (int i = 0; i < stk.size(); i++) chk($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(stk[i]));
  endtask

  task automatic chk_reset_state();
    chk("rst_top", 32'(top), 0);          chk("rst_depth", 32'(depth), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0); chk("rst_mem_data", 32'(mem_data), 0);
    chk("rst_mem_wren", 32'(mem_wren), 0); chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 0);
    chk("rst_err", 32'({err_ovf, err_unf, err_op}), 0);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] data;
    logic [DW-1:0] top;
    int            depth;
    logic [2:0]    err;
    int            lat;
    logic          ram_chk;
  } vec_t;

  vec_t tbl [30];

  initial begin
    int w0, w1;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    tbl[0]  = '{PUSH, 8'd5,   8'd5,   1, 3'b000, 1, 1'b0};
    tbl[1]  = '{PUSH, 8'd3,   8'd3,   2, 3'b000, 1, 1'b0};
    tbl[2]  = '{SUB,  8'd0,   8'd2,   1, 3'b000, 4, 1'b1};
    tbl[3]  = '{CLR,  8'd0,   8'd0,   0, 3'b000, 1, 1'b0};
    tbl[4]  = '{PUSH, 8'd200, 8'd200, 1, 3'b000, 1, 1'b0};
    tbl[5]  = '{PUSH, 8'd100, 8'd100, 2, 3'b000, 1, 1'b0};
    tbl[6]  = '{ADD,  8'd0,   8'd44,  1, 3'b000, 4, 1'b0};
    tbl[7]  = '{PUSH, 8'd16,  8'd16,  2, 3'b000, 1, 1'b0};
    tbl[8]  = '{PUSH, 8'd16,  8'd16,  3, 3'b000, 1, 1'b0};
    tbl[9]  = '{MUL,  8'd0,   8'd0,   2, 3'b000, 4, 1'b1};
    tbl[10] = '{CLR,  8'd0,   8'd0,   0, 3'b000, 1, 1'b0};
    tbl[11] = '{PUSH, 8'd1,   8'd1,   1, 3'b000, 1, 1'b0};
    tbl[12] = '{PUSH, 8'd2,   8'd2,   2, 3'b000, 1, 1'b0};
    tbl[13] = '{PUSH, 8'd3,   8'd3,   3, 3'b000, 1, 1'b0};
    tbl[14] = '{PUSH, 8'd4,   8'd4,   4, 3'b000, 1, 1'b0};
    tbl[15] = '{PUSH, 8'd5,   8'd4,   4, 3'b100, 1, 1'b1};
    tbl[16] = '{AND_, 8'd0,   8'd0,   3, 3'b000, 4, 1'b0};
    tbl[17] = '{CLR,  8'd0,   8'd0,   0, 3'b000, 1, 1'b0};
    tbl[18] = '{PUSH, 8'd7,   8'd7,   1, 3'b000, 1, 1'b0};
    tbl[19] = '{PUSH, 8'd9,   8'd9,   2, 3'b000, 1, 1'b0};
    tbl[20] = '{DROP, 8'd0,   8'd7,   1, 3'b000, 3, 1'b0};
    tbl[21] = '{DROP, 8'd0,   8'd0,   0, 3'b000, 1, 1'b0};
    tbl[22] = '{DROP, 8'd0,   8'd0,   0, 3'b010, 1, 1'b0};
    tbl[23] = '{ILL,  8'd0,   8'd0,   0, 3'b001, 1, 1'b0};
    tbl[24] = '{ADD,  8'd0,   8'd0,   0, 3'b010, 1, 1'b0};
    tbl[25] = '{PUSH, 8'd42,  8'd42,  1, 3'b000, 1, 1'b0};
    tbl[26] = '{ADD,  8'd0,   8'd42,  1, 3'b010, 1, 1'b0};
    tbl[27] = '{ILL,  8'd0,   8'd42,  1, 3'b001, 1, 1'b0};
    tbl[28] = '{PUSH, 8'd50,  8'd50,  2, 3'b000, 1, 1'b0};
    tbl[29] = '{SUB,  8'd0,   8'd248, 1, 3'b000, 4, 1'b1};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    chk("rst_ready", 32'(cmd_ready), 1);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      model_step(tbl[i].op, tbl[i].data);
      apply(tbl[i].op, tbl[i].data, tbl[i].top, tbl[i].depth, tbl[i].err, tbl[i].lat);
      if (tbl[i].ram_chk) check_ram();
    end

    // Reset while an ADD sits in CAP: everything clears and the pending write never happens.
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    stk.delete();
    model_step(PUSH, 8'd10); apply(PUSH, 8'd10, m_top, m_depth, m_err, m_lat);
    model_step(PUSH, 8'd20); apply(PUSH, 8'd20, m_top, m_depth, m_err, m_lat);
    check_ram();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("cap_ready_low", 32'(cmd_ready), 0);
    w0 = wr_seen;
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_state();
    chk("cap_rst_ready", 32'(cmd_ready), 1);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    w1 = wr_seen;
    chk("no_write_after_rst", 32'(w1), 32'(w0));
    chk("depth_after_rst", 32'(depth), 0);
    stk.delete();

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] op;
      logic [DW-1:0] d;
      r = $urandom_range(0, 19);
      if (r < 8 || r == 19) op = PUSH;
      else if (r < 14)      op = 3'((r - 8) % 4 + 1);
      else if (r < 17)      op = DROP;
      else if (r == 17)     op = CLR;
      else                  op = ILL;
      d = DW'($urandom);
      model_step(op, d);
      apply(op, d, m_top, m_depth, m_err, m_lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if (i % 25 == 24) check_ram();
    end
    check_ram();
    @(posedge clk); #1;
    chk("write_pulse_count", 32'(wr_seen), 32'(wr_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
